// File: rtl/hex_display_port_pkg.sv
// Shared constants for the hex display port: register offsets, CTRL bit
// positions and blink counter sizing.
package hex_display_port_pkg;

  localparam logic [7:0] OFF_LO    = 8'd0;
  localparam logic [7:0] OFF_HI    = 8'd1;
  localparam logic [7:0] OFF_CTRL  = 8'd2;
  localparam logic [7:0] REG_COUNT = 8'd3;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_BLINK = 1;

  localparam int BLINK_CNT_W = 26;

  typedef enum logic {
    BLK_OFF = 1'b0,
    BLK_ON  = 1'b1
  } blink_state_e;

  typedef struct packed {
    logic blink;
    logic en;
  } ctrl_t;

  function automatic ctrl_t ctrl_from_byte(input logic [7:0] b);
    ctrl_t c;
    c.en    = b[CTRL_EN];
    c.blink = b[CTRL_BLINK];
    return c;
  endfunction

endpackage

// File: rtl/hex_display_port_if.sv
// Processor-side byte bus seen by the hex display port.
interface hex_display_port_if;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_write;
  logic       bus_read;
  logic [7:0] bus_rdata;
  logic       bus_rvalid;

  modport master (
    output bus_addr, bus_wdata, bus_write, bus_read,
    input  bus_rdata, bus_rvalid
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_write, bus_read,
    output bus_rdata, bus_rvalid
  );
endinterface

// File: rtl/hex_display_port_blink_timer.sv
// Blink half-period timer: ON/OFF state plus a cycle counter, both forced
// back to the start of an ON half-period whenever run drops.
module hex_display_port_blink_timer
  import hex_display_port_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   run,
  input  logic [BLINK_CNT_W-1:0] period,
  output logic                   phase
);

  blink_state_e           state, state_d;
  logic [BLINK_CNT_W-1:0] cnt, cnt_d;
  logic                   run_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= BLK_ON;
      cnt   <= '0;
      run_q <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      run_q <= run;
    end
  end

  // run is the post-write control value, so a stop clears in the same edge;
  // counting only begins once run was already high, giving a full first ON.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    if (!run) begin
      state_d = BLK_ON;
      cnt_d   = '0;
    end else if (run_q) begin
      if (cnt == period - BLINK_CNT_W'(1)) begin
        cnt_d   = '0;
        state_d = (state == BLK_ON) ? BLK_OFF : BLK_ON;
      end else begin
        cnt_d = cnt + BLINK_CNT_W'(1);
      end
    end
  end

  assign phase = (state == BLK_ON);

endmodule

// File: rtl/hex_display_port.sv
// Memory-mapped seven-segment display port: LO/HI byte assembly with atomic
// commit, enable/blink control, optional read-back (HEX_DISPLAY_PORT_READBACK_EN).
module hex_display_port
  import hex_display_port_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR    = 8'hF0,
  parameter int         BLINK_PERIOD = 25000000
) (
  input  logic                clock,
  input  logic                reset,
  hex_display_port_if.slave   bus,
  output logic [15:0]         display_value,
  output logic                display_enable
);

  localparam logic [BLINK_CNT_W-1:0] PERIOD = BLINK_CNT_W'(BLINK_PERIOD);

  logic [7:0] off;
  logic       in_range;
  logic       wr_hit;
  logic [7:0] shadow_lo;
  ctrl_t      ctrl_q, ctrl_d;
  logic       run;
  logic       phase;

  assign off      = bus.bus_addr - BASE_ADDR;
  assign in_range = (off < REG_COUNT);
  assign wr_hit   = bus.bus_write & in_range;

  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_hit && off == OFF_CTRL) ctrl_d = ctrl_from_byte(bus.bus_wdata);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_lo     <= 8'h00;
      display_value <= 16'h0000;
      ctrl_q        <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      if (wr_hit && off == OFF_LO) shadow_lo <= bus.bus_wdata;
      if (wr_hit && off == OFF_HI) display_value <= {bus.bus_wdata, shadow_lo};
    end
  end

  assign run = ctrl_d.en & ctrl_d.blink;

  hex_display_port_blink_timer u_blink (
    .clock  (clock),
    .reset  (reset),
    .run    (run),
    .period (PERIOD),
    .phase  (phase)
  );

  assign display_enable = ctrl_q.en & (~ctrl_q.blink | phase);

`ifdef HEX_DISPLAY_PORT_READBACK_EN
  logic       rd_hit;
  logic [7:0] rd_mux;
  logic [7:0] rdata_q;
  logic       rvalid_q;

  assign rd_hit = bus.bus_read & in_range;

  // Mux reads register state before this edge's write, so a same-offset
  // read+write returns the old value.
  always_comb begin
    rd_mux = 8'h00;
    case (off)
      OFF_LO:   rd_mux = shadow_lo;
      OFF_HI:   rd_mux = display_value[15:8];
      OFF_CTRL: rd_mux = {6'b0, ctrl_q.blink, ctrl_q.en};
      default:  rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q  <= 8'h00;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_hit;
      if (rd_hit) rdata_q <= rd_mux;
    end
  end

  assign bus.bus_rdata  = rdata_q;
  assign bus.bus_rvalid = rvalid_q;
`else
  logic unused_read;
  assign unused_read    = bus.bus_read;
  assign bus.bus_rdata  = 8'h00;
  assign bus.bus_rvalid = 1'b0;
`endif

endmodule
